// File: rtl/atb_pkg.sv
// Shared ATB sink types: beat record, reserved trace IDs and flush handshake states.
package atb_pkg;

  localparam logic [6:0] ATB_ID_NULL    = 7'h00;
  localparam logic [6:0] ATB_ID_RSVD_LO = 7'h70;

  typedef struct packed {
    logic [6:0]  id;
    logic [1:0]  bytes;
    logic [31:0] data;
  } atb_beat_t;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_REQ  = 2'd1,
    FL_DONE = 2'd2
  } flush_state_t;

  function automatic logic id_is_rsvd(input logic [6:0] id);
    return id >= ATB_ID_RSVD_LO;
  endfunction

endpackage

// File: rtl/atb_sync_fifo.sv
// Generic single-clock FIFO with occupancy count; head word read combinationally from storage.
// Data visible one cycle after push; push is dropped when full, pop ignored when empty.
module atb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/atb_rx_sink.sv
// ATB receive sink: filters null/reserved IDs into a FIFO, runs the flush handshake and periodic syncreq.
// Beats reach out_* one cycle after acceptance; atready drops only when the FIFO is full.
module atb_rx_sink
  import atb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_PERIOD = 1024
) (
  input  logic        atclk,
  input  logic        atresetn,
  input  logic        atclken,
  input  logic        atvalid,
  output logic        atready,
  input  logic [31:0] atdata,
  input  logic [1:0]  atbytes,
  input  logic [6:0]  atid,
  output logic        afvalid,
  input  logic        afready,
  output logic        syncreq,
  input  logic        atwakeup,
  input  logic        flush_req,
  input  logic        sync_force,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_bytes,
  output logic [6:0]  out_id,
  output logic        flush_done,
  output logic        err_rsvd_id,
  output logic        idle
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);

  logic [CW-1:0] fifo_count;
  logic          accept;
  logic          id_rsvd;
  logic          push;
  logic          pop;
  atb_beat_t     wr_beat;
  atb_beat_t     rd_beat;
  flush_state_t  state_q;
  flush_state_t  state_d;
  logic [SW-1:0] sync_cnt;
  logic          sync_wrap;

  assign atready   = fifo_count < CW'(FIFO_DEPTH);
  assign accept    = atclken && atvalid && atready;
  assign id_rsvd   = id_is_rsvd(atid);
  assign push      = accept && (atid != ATB_ID_NULL) && !id_rsvd;
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid && out_ready;
  assign wr_beat   = '{id: atid, bytes: atbytes, data: atdata};
  assign out_data  = rd_beat.data;
  assign out_bytes = rd_beat.bytes;
  assign out_id    = rd_beat.id;
  assign idle      = (fifo_count == '0) && (state_q == FL_IDLE) && !atwakeup;

  atb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(atb_beat_t))
  ) u_fifo (
    .clk       (atclk),
    .rst_n     (atresetn),
    .push      (push),
    .push_data (wr_beat),
    .pop       (pop),
    .pop_data  (rd_beat),
    .count     (fifo_count)
  );

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) state_q <= FL_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FL_IDLE: if (flush_req) state_d = FL_REQ;
      FL_REQ:  if (atclken && afready) state_d = FL_DONE;
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    afvalid    = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      FL_REQ:  afvalid = 1'b1;
      FL_DONE: flush_done = 1'b1;
      default: ;
    endcase
  end

  assign sync_wrap = accept && (sync_cnt == SYNC_LAST);

  // A forced sync coinciding with a wrap still yields one pulse; it stretches until an enabled edge.
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      sync_cnt    <= '0;
      syncreq     <= 1'b0;
      err_rsvd_id <= 1'b0;
    end else begin
      if (sync_force)  sync_cnt <= '0;
      else if (accept) sync_cnt <= sync_wrap ? '0 : sync_cnt + SW'(1);
      if (sync_force || sync_wrap) syncreq <= 1'b1;
      else if (atclken)            syncreq <= 1'b0;
      if (accept && id_rsvd) err_rsvd_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atb_rx_sink.sv
// Directed bench for atb_rx_sink: vector table for FIFO/filter behaviour plus flush, clock-enable, sync and reset sequences.
module tb_atb_rx_sink;

  logic        atclk = 1'b0;
  logic        atresetn;
  logic        atclken;
  logic        atvalid;
  logic        atready;
  logic [31:0] atdata;
  logic [1:0]  atbytes;
  logic [6:0]  atid;
  logic        afvalid;
  logic        afready;
  logic        syncreq;
  logic        atwakeup;
  logic        flush_req;
  logic        sync_force;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_bytes;
  logic [6:0]  out_id;
  logic        flush_done;
  logic        err_rsvd_id;
  logic        idle;

  int tests = 0;
  int fails = 0;

  always #5 atclk = ~atclk;
  assign atbytes = atdata[1:0];

  atb_rx_sink #(.FIFO_DEPTH(4), .SYNC_PERIOD(4)) dut (
    .atclk(atclk), .atresetn(atresetn), .atclken(atclken), .atvalid(atvalid),
    .atready(atready), .atdata(atdata), .atbytes(atbytes), .atid(atid),
    .afvalid(afvalid), .afready(afready), .syncreq(syncreq), .atwakeup(atwakeup),
    .flush_req(flush_req), .sync_force(sync_force), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes), .out_id(out_id),
    .flush_done(flush_done), .err_rsvd_id(err_rsvd_id), .idle(idle)
  );

  typedef struct {
    logic        vld;
    logic [6:0]  id;
    logic [31:0] data;
    logic        ordy;
    logic        e_rdy;
    logic        e_ovld;
    logic [6:0]  e_oid;
    logic [31:0] e_odata;
    logic        e_err;
  } vec_t;

  vec_t vt [17];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    atresetn   = 1'b0;
    atclken    = 1'b1;
    atvalid    = 1'b0;
    atdata     = '0;
    atid       = '0;
    afready    = 1'b0;
    atwakeup   = 1'b0;
    flush_req  = 1'b0;
    sync_force = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge atclk);
    atresetn = 1'b1;
    @(negedge atclk);
  endtask

  initial begin
    // vld id data ordy | rdy ovld oid odata err  (expected values are before the edge)
    vt[0]  = '{1'b1, 7'h10, 32'hA0, 1'b0, 1'b1, 1'b0, 7'h00, 32'h00, 1'b0};
    vt[1]  = '{1'b1, 7'h10, 32'hA1, 1'b0, 1'b1, 1'b1, 7'h10, 32'hA0, 1'b0};
    vt[2]  = '{1'b1, 7'h10, 32'hA2, 1'b0, 1'b1, 1'b1, 7'h10, 32'hA0, 1'b0};
    vt[3]  = '{1'b1, 7'h10, 32'hA3, 1'b0, 1'b1, 1'b1, 7'h10, 32'hA0, 1'b0};
    vt[4]  = '{1'b1, 7'h10, 32'hA4, 1'b0, 1'b0, 1'b1, 7'h10, 32'hA0, 1'b0};
    vt[5]  = '{1'b1, 7'h10, 32'hA4, 1'b1, 1'b0, 1'b1, 7'h10, 32'hA0, 1'b0};
    vt[6]  = '{1'b1, 7'h10, 32'hA4, 1'b0, 1'b1, 1'b1, 7'h10, 32'hA1, 1'b0};
    vt[7]  = '{1'b0, 7'h10, 32'h00, 1'b1, 1'b0, 1'b1, 7'h10, 32'hA1, 1'b0};
    vt[8]  = '{1'b0, 7'h10, 32'h00, 1'b1, 1'b1, 1'b1, 7'h10, 32'hA2, 1'b0};
    vt[9]  = '{1'b0, 7'h10, 32'h00, 1'b1, 1'b1, 1'b1, 7'h10, 32'hA3, 1'b0};
    vt[10] = '{1'b0, 7'h10, 32'h00, 1'b1, 1'b1, 1'b1, 7'h10, 32'hA4, 1'b0};
    vt[11] = '{1'b1, 7'h00, 32'hB0, 1'b1, 1'b1, 1'b0, 7'h00, 32'h00, 1'b0};
    vt[12] = '{1'b1, 7'h72, 32'hB1, 1'b1, 1'b1, 1'b0, 7'h00, 32'h00, 1'b0};
    vt[13] = '{1'b1, 7'h11, 32'hC0, 1'b1, 1'b1, 1'b0, 7'h00, 32'h00, 1'b1};
    vt[14] = '{1'b1, 7'h12, 32'hC1, 1'b1, 1'b1, 1'b1, 7'h11, 32'hC0, 1'b1};
    vt[15] = '{1'b0, 7'h00, 32'h00, 1'b1, 1'b1, 1'b1, 7'h12, 32'hC1, 1'b1};
    vt[16] = '{1'b0, 7'h00, 32'h00, 1'b0, 1'b1, 1'b0, 7'h00, 32'h00, 1'b1};

    atresetn = 1'b0; atclken = 1'b1; atvalid = 1'b0; atdata = '0; atid = '0;
    afready = 1'b0; atwakeup = 1'b0; flush_req = 1'b0; sync_force = 1'b0; out_ready = 1'b0;
    #3;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_afvalid", afvalid, 1'b0);
    chk1("rst_flush_done", flush_done, 1'b0);
    chk1("rst_syncreq", syncreq, 1'b0);
    chk1("rst_err", err_rsvd_id, 1'b0);
    do_reset();
    chk1("rel_atready", atready, 1'b1);
    chk1("rel_idle", idle, 1'b1);
    atwakeup = 1'b1; #1;
    chk1("idle_wakeup", idle, 1'b0);
    atwakeup = 1'b0;

    // Fill, stall, pop-one, drain, then null / reserved IDs and push-with-pop.
    for (int i = 0; i < 17; i++) begin
      @(negedge atclk);
      atvalid = vt[i].vld; atid = vt[i].id; atdata = vt[i].data; out_ready = vt[i].ordy;
      #1;
      chk1($sformatf("v%0d_atready", i), atready, vt[i].e_rdy);
      chk1($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ovld);
      chk1($sformatf("v%0d_err", i), err_rsvd_id, vt[i].e_err);
      if (vt[i].e_ovld) begin
        chk32($sformatf("v%0d_out_id", i), 32'(out_id), 32'(vt[i].e_oid));
        chk32($sformatf("v%0d_out_data", i), out_data, vt[i].e_odata);
        chk32($sformatf("v%0d_out_bytes", i), 32'(out_bytes), 32'(vt[i].e_odata[1:0]));
      end
    end

    // Flush: afready after 3 REQ cycles, beats accepted meanwhile, second flush_req ignored.
    @(negedge atclk);
    atvalid = 1'b0; out_ready = 1'b0; flush_req = 1'b1;
    chk1("fl_pre_afvalid", afvalid, 1'b0);
    @(negedge atclk);
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("fl_req%0d_afvalid", i), afvalid, 1'b1);
      chk1($sformatf("fl_req%0d_done", i), flush_done, 1'b0);
      chk1($sformatf("fl_req%0d_atready", i), atready, 1'b1);
      atvalid = 1'b1; atid = 7'h20; atdata = 32'hD0 + 32'(i);
      afready = (i == 2); flush_req = (i == 1);
      @(negedge atclk);
    end
    atvalid = 1'b0; afready = 1'b0; flush_req = 1'b0;
    chk1("fl_done_pulse", flush_done, 1'b1);
    chk1("fl_done_afvalid", afvalid, 1'b0);
    @(negedge atclk);
    chk1("fl_after_done", flush_done, 1'b0);
    chk1("fl_after_afvalid", afvalid, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("fl_drain%0d_valid", i), out_valid, 1'b1);
      chk32($sformatf("fl_drain%0d_data", i), out_data, 32'hD0 + 32'(i));
      @(negedge atclk);
    end
    chk1("fl_drained", out_valid, 1'b0);

    // Clock enable: only enabled edges transfer; afready ignored while disabled.
    do_reset();
    atvalid = 1'b1; atid = 7'h30;
    for (int c = 0; c < 4; c++) begin
      atclken = (c % 2 == 0);
      atdata = 32'h100 + 32'(c);
      @(negedge atclk);
    end
    atvalid = 1'b0; atclken = 1'b1; out_ready = 1'b1;
    chk1("ce_valid0", out_valid, 1'b1);
    chk32("ce_data0", out_data, 32'h100);
    @(negedge atclk);
    chk1("ce_valid1", out_valid, 1'b1);
    chk32("ce_data1", out_data, 32'h102);
    @(negedge atclk);
    chk1("ce_empty", out_valid, 1'b0);
    out_ready = 1'b0; flush_req = 1'b1;
    @(negedge atclk);
    flush_req = 1'b0; afready = 1'b1; atclken = 1'b0;
    @(negedge atclk);
    chk1("ce_afready_ignored", afvalid, 1'b1);
    atclken = 1'b1;
    @(negedge atclk);
    chk1("ce_flush_done", flush_done, 1'b1);
    afready = 1'b0;
    @(negedge atclk);

    // Sync period 4 with a discarded null beat counted; forces on beats 4 and 6.
    do_reset();
    out_ready = 1'b1;
    chk1("sy_reset", syncreq, 1'b0);
    atvalid = 1'b1; atid = 7'h40; atdata = 32'h55;
    for (int k = 1; k <= 10; k++) begin
      @(negedge atclk);
      chk1($sformatf("sy_beat%0d", k), syncreq, (k == 4 || k == 6 || k == 10));
      atid = (k + 1 == 2) ? 7'h00 : 7'h40;
      sync_force = (k + 1 == 4 || k + 1 == 6);
      if (k == 10) begin
        atvalid = 1'b0; atclken = 1'b0;
      end
    end
    @(negedge atclk);
    chk1("sy_hold_ce_low", syncreq, 1'b1);
    atclken = 1'b1;
    @(negedge atclk);
    chk1("sy_release", syncreq, 1'b0);

    // Reset during REQ with 3 beats buffered.
    do_reset();
    atvalid = 1'b1; atid = 7'h50; atdata = 32'hE0;
    repeat (3) @(negedge atclk);
    atvalid = 1'b0; flush_req = 1'b1;
    @(negedge atclk);
    flush_req = 1'b0;
    chk1("rr_afvalid_pre", afvalid, 1'b1);
    chk1("rr_valid_pre", out_valid, 1'b1);
    #2 atresetn = 1'b0;
    #1;
    chk1("rr_out_valid", out_valid, 1'b0);
    chk1("rr_afvalid", afvalid, 1'b0);
    @(negedge atclk);
    atresetn = 1'b1; afready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge atclk);
      chk1($sformatf("rr_no_done%0d", i), flush_done, 1'b0);
      chk1($sformatf("rr_no_req%0d", i), afvalid, 1'b0);
      chk1($sformatf("rr_empty%0d", i), out_valid, 1'b0);
    end
    afready = 1'b0; atvalid = 1'b1; atdata = 32'hF0;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("rr_room%0d", i), atready, 1'b1);
      @(negedge atclk);
    end
    atvalid = 1'b0;
    chk1("rr_full_after4", atready, 1'b0);
    chk1("rr_not_idle", idle, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
